// File: rtl/datapath_p.sv
// rtl/datapath_p.sv - LC-3 style datapath with bus, register file, condition codes and timed memory-read FSM.
// Optional DATAPATH_BUS_CHECK_EN flags simultaneous bus drivers in a sticky BUS_ERR.
module datapath_p #(
    parameter int W       = 16,
    parameter int LED_W   = 12,
    parameter int TIMEOUT = 255
) (
    input  logic             Clk,
    input  logic             Reset_al,
    input  logic [7:0]       LD,
    input  logic [3:0]       GATE,
    input  logic [9:0]       MUXSEL,
    input  logic             MEM_RD,
    input  logic [W-1:0]     MDR_In,
    input  logic             MEM_RDY,
    output logic             MEM_REQ,
    output logic             MDR_VALID,
    output logic             MEM_TO,
    output logic [W-1:0]     IR,
    output logic [W-1:0]     PC,
    output logic [W-1:0]     MAR,
    output logic [W-1:0]     MDR,
    output logic [2:0]       NZP,
    output logic             BEN,
    output logic [LED_W-1:0] LED,
    output logic             BUS_ERR
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {S_IDLE, S_WAIT} mem_state_e;

    mem_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [W-1:0]      pc_q, pc_d, ir_q, ir_d, mar_q, mar_d, mdr_q, mdr_d;
    logic [W-1:0]      rf_q [8];
    logic [W-1:0]      rf_d [8];
    logic [2:0]        nzp_q, nzp_d;
    logic              ben_q, ben_d, valid_q, valid_d, to_q, to_d, bus_err_q, bus_err_d;
    logic [LED_W-1:0]  led_q, led_d;

    logic [1:0]        pcmux, addr2mux, aluk;
    logic              addr1mux, sr2mux, sr1mux, drmux;
    logic [2:0]        dr, sr1, sr2;
    logic [W-1:0]      sext11, sext9, sext6, sext5;
    logic [W-1:0]      sr1_val, sr2_val, alu_b, alu_out, addr1, addr2, adder_out, bus;

    assign pcmux    = MUXSEL[1:0];
    assign addr2mux = MUXSEL[3:2];
    assign aluk     = MUXSEL[5:4];
    assign addr1mux = MUXSEL[6];
    assign sr2mux   = MUXSEL[7];
    assign sr1mux   = MUXSEL[8];
    assign drmux    = MUXSEL[9];

    assign sext11 = {{(W-11){ir_q[10]}}, ir_q[10:0]};
    assign sext9  = {{(W-9){ir_q[8]}}, ir_q[8:0]};
    assign sext6  = {{(W-6){ir_q[5]}}, ir_q[5:0]};
    assign sext5  = {{(W-5){ir_q[4]}}, ir_q[4:0]};

    assign dr  = drmux ? 3'd7 : ir_q[11:9];
    assign sr1 = sr1mux ? ir_q[8:6] : ir_q[11:9];
    assign sr2 = ir_q[2:0];

    // Combinational reads: a same-cycle write is seen only after the edge.
    assign sr1_val = rf_q[sr1];
    assign sr2_val = rf_q[sr2];
    assign alu_b   = sr2mux ? sext5 : sr2_val;

    always_comb begin
        alu_out = sr1_val;
        case (aluk)
            2'b00:   alu_out = sr1_val + alu_b;
            2'b01:   alu_out = sr1_val & alu_b;
            2'b10:   alu_out = ~sr1_val;
            default: alu_out = sr1_val;
        endcase
    end

    always_comb begin
        addr1 = addr1mux ? sr1_val : pc_q;
        addr2 = '0;
        case (addr2mux)
            2'b00:   addr2 = sext11;
            2'b01:   addr2 = sext9;
            2'b10:   addr2 = sext6;
            default: addr2 = '0;
        endcase
        adder_out = addr1 + addr2;
    end

    // Fixed priority keeps BUS deterministic even when several gates are on.
    always_comb begin
        bus = '0;
        if (GATE[0])      bus = alu_out;
        else if (GATE[1]) bus = pc_q;
        else if (GATE[2]) bus = adder_out;
        else if (GATE[3]) bus = mdr_q;
    end

    always_comb begin
        pc_d      = pc_q;
        ir_d      = ir_q;
        mar_d     = mar_q;
        nzp_d     = nzp_q;
        ben_d     = ben_q;
        led_d     = led_q;
        rf_d      = rf_q;
        bus_err_d = bus_err_q;
        if (LD[0]) begin
            case (pcmux)
                2'b00:   pc_d = bus;
                2'b01:   pc_d = adder_out;
                2'b10:   pc_d = pc_q + W'(1);
                default: pc_d = pc_q;
            endcase
        end
        if (LD[1]) ir_d  = bus;
        if (LD[2]) mar_d = bus;
        if (LD[4]) ben_d = (ir_q[11] & nzp_q[2]) | (ir_q[10] & nzp_q[1]) | (ir_q[9] & nzp_q[0]);
        if (LD[5]) begin
            if (bus[W-1])      nzp_d = 3'b100;
            else if (bus == '0) nzp_d = 3'b010;
            else               nzp_d = 3'b001;
        end
        if (LD[6]) rf_d[dr] = bus;
        if (LD[7]) led_d = ir_q[LED_W-1:0];
`ifdef DATAPATH_BUS_CHECK_EN
        bus_err_d = bus_err_q | ((GATE & (GATE - 4'd1)) != 4'd0);
`else
        bus_err_d = 1'b0;
`endif
    end

    // Memory read FSM; MDR_VALID is registered so it lines up with the new MDR.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mdr_d   = mdr_q;
        valid_d = 1'b0;
        to_d    = to_q;
        case (state_q)
            S_IDLE: begin
                if (LD[3]) mdr_d = bus;
                if (MEM_RD) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (MEM_RDY) begin
                    mdr_d   = MDR_In;
                    valid_d = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // cnt_q counts finished wait cycles, so this is wait cycle TIMEOUT.
                    mdr_d   = '0;
                    valid_d = 1'b1;
                    to_d    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_al) begin
        if (!Reset_al) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pc_q      <= '0;
            ir_q      <= '0;
            mar_q     <= '0;
            mdr_q     <= '0;
            nzp_q     <= '0;
            ben_q     <= 1'b0;
            led_q     <= '0;
            valid_q   <= 1'b0;
            to_q      <= 1'b0;
            bus_err_q <= 1'b0;
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mar_q     <= mar_d;
            mdr_q     <= mdr_d;
            nzp_q     <= nzp_d;
            ben_q     <= ben_d;
            led_q     <= led_d;
            valid_q   <= valid_d;
            to_q      <= to_d;
            bus_err_q <= bus_err_d;
            for (int i = 0; i < 8; i++) rf_q[i] <= rf_d[i];
        end
    end

    assign MEM_REQ   = (state_q == S_WAIT);
    assign MDR_VALID = valid_q;
    assign MEM_TO    = to_q;
    assign IR        = ir_q;
    assign PC        = pc_q;
    assign MAR       = mar_q;
    assign MDR       = mdr_q;
    assign NZP       = nzp_q;
    assign BEN       = ben_q;
    assign LED       = led_q;
    assign BUS_ERR   = bus_err_q;
endmodule

// File: tb/tb_datapath_p.sv
// tb/tb_datapath_p.sv - scoreboard bench for datapath_p: read completions and register checks queued, monitor compares.
module tb_datapath_p;
    localparam logic [7:0] LD_PC = 8'h01, LD_IR = 8'h02, LD_MAR = 8'h04, LD_MDR = 8'h08;
    localparam logic [7:0] LD_BEN = 8'h10, LD_CC = 8'h20, LD_REG = 8'h40, LD_LED = 8'h80;
    localparam logic [3:0] G_ALU = 4'h1, G_PC = 4'h2, G_MARMUX = 4'h4, G_MDR = 4'h8;
    localparam int S_PC = 0, S_IR = 1, S_MAR = 2, S_MDR = 3, S_NZP = 4, S_BEN = 5;
    localparam int S_LED = 6, S_TO = 7, S_BERR = 8, S_REQ = 9, S_VAL = 10;
`ifdef DATAPATH_BUS_CHECK_EN
    localparam logic EXP_BERR = 1'b1;
`else
    localparam logic EXP_BERR = 1'b0;
`endif

    logic        Clk = 1'b0, Reset_al = 1'b0;
    logic [7:0]  LD = '0;
    logic [3:0]  GATE = '0;
    logic [9:0]  MUXSEL = '0;
    logic        MEM_RD = 1'b0, MEM_RDY = 1'b0;
    logic [15:0] MDR_In = '0;
    logic        MEM_REQ, MDR_VALID, MEM_TO, BEN, BUS_ERR;
    logic [15:0] IR, PC, MAR, MDR;
    logic [2:0]  NZP;
    logic [11:0] LED;

    datapath_p #(.W(16), .LED_W(12), .TIMEOUT(4)) dut (
        .Clk(Clk), .Reset_al(Reset_al), .LD(LD), .GATE(GATE), .MUXSEL(MUXSEL),
        .MEM_RD(MEM_RD), .MDR_In(MDR_In), .MEM_RDY(MEM_RDY), .MEM_REQ(MEM_REQ),
        .MDR_VALID(MDR_VALID), .MEM_TO(MEM_TO), .IR(IR), .PC(PC), .MAR(MAR), .MDR(MDR),
        .NZP(NZP), .BEN(BEN), .LED(LED), .BUS_ERR(BUS_ERR)
    );

    always #5 Clk = ~Clk;

    typedef struct { int sel; logic [31:0] exp; string name; } chk_t;
    typedef struct { logic [15:0] data; logic to; int req; } rd_t;
    chk_t chk_q[$];
    rd_t  rd_q[$];
    int   n_cmp = 0, n_err = 0, req_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            S_PC:    return {16'h0, PC};
            S_IR:    return {16'h0, IR};
            S_MAR:   return {16'h0, MAR};
            S_MDR:   return {16'h0, MDR};
            S_NZP:   return {29'h0, NZP};
            S_BEN:   return {31'h0, BEN};
            S_LED:   return {20'h0, LED};
            S_TO:    return {31'h0, MEM_TO};
            S_BERR:  return {31'h0, BUS_ERR};
            S_REQ:   return {31'h0, MEM_REQ};
            default: return {31'h0, MDR_VALID};
        endcase
    endfunction

    // Monitor: consumes read completions on MDR_VALID and any queued register checks.
    always @(negedge Clk) begin
        rd_t  r;
        chk_t c;
        if (!Reset_al) begin
            req_cnt = 0;
        end else begin
            if (MEM_REQ) req_cnt++;
            if (MDR_VALID) begin
                if (rd_q.size() == 0) begin
                    check("unexpected_mdr_valid", 32'd1, 32'd0);
                end else begin
                    r = rd_q.pop_front();
                    check("rd_mdr", {16'h0, MDR}, {16'h0, r.data});
                    check("rd_mem_to", {31'h0, MEM_TO}, {31'h0, r.to});
                    check("rd_req_cycles", req_cnt, r.req);
                end
                req_cnt = 0;
            end
        end
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            check(c.name, obs(c.sel), c.exp);
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic expect_reg(input int sel, input logic [31:0] v, input string nm);
        chk_t c;
        c.sel = sel; c.exp = v; c.name = nm;
        chk_q.push_back(c);
    endtask

    task automatic op(input logic [7:0] ld, input logic [3:0] g, input logic [9:0] ms);
        LD = ld; GATE = g; MUXSEL = ms;
        step();
        LD = '0; GATE = '0; MUXSEL = '0;
    endtask

    task automatic mem_read(input logic [15:0] d, input int n, input logic to);
        rd_t r;
        r.data = d; r.to = to; r.req = n;
        rd_q.push_back(r);
        MEM_RD = 1'b1;
        step();
        MEM_RD = 1'b0;
        repeat (n - 1) step();
        MEM_RDY = 1'b1; MDR_In = d;
        step();
        MEM_RDY = 1'b0;
    endtask

    task automatic expect_reset_state(input string tag);
        expect_reg(S_PC, 0, {tag, "_pc"});
        expect_reg(S_IR, 0, {tag, "_ir"});
        expect_reg(S_MAR, 0, {tag, "_mar"});
        expect_reg(S_MDR, 0, {tag, "_mdr"});
        expect_reg(S_NZP, 0, {tag, "_nzp"});
        expect_reg(S_BEN, 0, {tag, "_ben"});
        expect_reg(S_LED, 0, {tag, "_led"});
        expect_reg(S_TO, 0, {tag, "_mem_to"});
        expect_reg(S_BERR, 0, {tag, "_bus_err"});
        expect_reg(S_REQ, 0, {tag, "_mem_req"});
        expect_reg(S_VAL, 0, {tag, "_mdr_valid"});
    endtask

    initial begin
        rd_t r;
        int  k;
        step(); step();
        expect_reset_state("rst");
        step();
        Reset_al = 1'b1;
        step();

        mem_read(16'hBEEF, 3, 1'b0);
        expect_reg(S_MDR, 32'hBEEF, "mdr_beef");

        mem_read(16'h1261, 1, 1'b0);
        op(LD_IR, G_MDR, 10'h000);
        expect_reg(S_IR, 32'h1261, "ir_load");
        mem_read(16'hFFFF, 2, 1'b0);
        op(LD_REG, G_MDR, 10'h000);
        op(LD_PC, G_MDR, 10'h000);
        expect_reg(S_PC, 32'hFFFF, "pc_from_bus");
        op(LD_PC, 4'h0, 10'h002);
        expect_reg(S_PC, 32'h0000, "pc_wrap");
        op(LD_PC, 4'h0, 10'h002);
        op(LD_PC, 4'h0, 10'h003);
        expect_reg(S_PC, 32'h0001, "pc_hold");

        op(LD_MAR, G_MDR, 10'h000);
        expect_reg(S_MAR, 32'hFFFF, "mar_from_mdr");
        op(LD_REG | LD_CC, G_ALU, 10'h180);
        expect_reg(S_NZP, 32'h2, "add_r1_nzp_z");
        op(LD_MAR, G_ALU, 10'h130);
        expect_reg(S_MAR, 32'h0000, "r1_wrapped_zero");

        op(LD_MAR, G_MARMUX, 10'h000);
        expect_reg(S_MAR, 32'h0262, "adder_pc_sext11");
        op(LD_MAR, G_MARMUX, 10'h004);
        expect_reg(S_MAR, 32'h0062, "adder_pc_sext9");
        op(LD_MAR, G_MARMUX, 10'h008);
        expect_reg(S_MAR, 32'hFFE2, "adder_pc_sext6_neg");
        op(LD_MAR, G_MARMUX, 10'h048);
        expect_reg(S_MAR, 32'hFFE1, "adder_sr1_sext6");
        op(LD_PC, 4'h0, 10'h005);
        expect_reg(S_PC, 32'h0062, "pc_from_adder");

        op(LD_REG, G_MDR, 10'h200);
        mem_read(16'h0E7A, 1, 1'b0);
        op(LD_IR, G_MDR, 10'h000);
        op(LD_MAR, G_ALU, 10'h090);
        expect_reg(S_MAR, 32'hFFFA, "alu_and_imm");
        op(LD_MAR, G_ALU, 10'h010);
        expect_reg(S_MAR, 32'h0000, "alu_and_reg");
        op(LD_MAR | LD_CC, G_ALU, 10'h080);
        expect_reg(S_MAR, 32'hFFF9, "alu_add_imm_neg");
        expect_reg(S_NZP, 32'h4, "nzp_n");
        op(LD_MAR, G_ALU, 10'h120);
        expect_reg(S_MAR, 32'hFFFF, "alu_not");
        op(LD_LED, 4'h0, 10'h000);
        expect_reg(S_LED, 32'hE7A, "led_load");
        op(LD_MAR | LD_CC, 4'h0, 10'h000);
        expect_reg(S_MAR, 32'h0000, "bus_idle_zero");
        expect_reg(S_NZP, 32'h2, "nzp_z_idle_bus");

        mem_read(16'h0800, 2, 1'b0);
        op(LD_IR, G_MDR, 10'h000);
        mem_read(16'h8000, 1, 1'b0);
        op(LD_CC, G_MDR, 10'h000);
        expect_reg(S_NZP, 32'h4, "nzp_n_8000");
        op(LD_BEN, 4'h0, 10'h000);
        expect_reg(S_BEN, 32'h1, "ben_n_taken");
        mem_read(16'h0200, 1, 1'b0);
        op(LD_IR, G_MDR, 10'h000);
        op(LD_BEN | LD_CC, G_MDR, 10'h000);
        expect_reg(S_BEN, 32'h0, "ben_old_nzp");
        expect_reg(S_NZP, 32'h1, "nzp_p");
        op(LD_BEN, 4'h0, 10'h000);
        expect_reg(S_BEN, 32'h1, "ben_p_taken");

        op(LD_MDR, G_PC, 10'h000);
        expect_reg(S_MDR, 32'h0062, "mdr_from_bus_idle");
        op(LD_MAR, 4'b0011, 10'h020);
        expect_reg(S_MAR, 32'hFFFF, "bus_prio_alu");
        expect_reg(S_BERR, {31'h0, EXP_BERR}, "bus_err_set");
        op(LD_MAR, 4'b1100, 10'h000);
        expect_reg(S_MAR, 32'h0262, "bus_prio_marmux");
        op(LD_MAR, G_MDR, 10'h000);
        expect_reg(S_MAR, 32'h0062, "bus_mdr_only");
        expect_reg(S_BERR, {31'h0, EXP_BERR}, "bus_err_sticky");

        MEM_RDY = 1'b1; MDR_In = 16'h1234;
        step();
        MEM_RDY = 1'b0;
        expect_reg(S_MDR, 32'h0062, "rdy_in_idle_ignored");

        r.data = 16'h7777; r.to = 1'b0; r.req = 2;
        rd_q.push_back(r);
        MEM_RD = 1'b1;
        step();
        LD = LD_MDR; GATE = G_PC;
        step();
        LD = '0; GATE = '0;
        expect_reg(S_MDR, 32'h0062, "ld_mdr_in_wait_ignored");
        MEM_RDY = 1'b1; MDR_In = 16'h7777;
        step();
        MEM_RDY = 1'b0; MEM_RD = 1'b0;

        mem_read(16'hABCD, 4, 1'b0);
        expect_reg(S_TO, 32'h0, "rdy_wins_at_timeout");

        r.data = 16'h0000; r.to = 1'b1; r.req = 4;
        rd_q.push_back(r);
        MEM_RD = 1'b1;
        step();
        MEM_RD = 1'b0;
        k = 0;
        while (!MDR_VALID && k < 20) begin
            step();
            k++;
        end
        if (!MDR_VALID) check("timeout_pulse_seen", 32'd0, 32'd1);
        expect_reg(S_TO, 32'h1, "mem_to_set");
        expect_reg(S_MDR, 32'h0, "mdr_zero_on_timeout");
        mem_read(16'h5555, 1, 1'b1);
        expect_reg(S_TO, 32'h1, "mem_to_sticky");

        MEM_RD = 1'b1;
        step();
        MEM_RD = 1'b0;
        step();
        Reset_al = 1'b0;
        #1;
        expect_reset_state("rst_wait");
        step(); step();
        Reset_al = 1'b1;
        repeat (6) step();
        expect_reg(S_REQ, 32'h0, "idle_after_abort");

        mem_read(16'h1111, 2, 1'b0);
        repeat (3) step();
        check("reads_drained", rd_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/datapath_p.md
DATAPATH_P -- requirements
Module: datapath_p

Interface
REQ-001 Parameter W, default 16, data/bus width; SHALL be >= 16.
REQ-002 Parameter LED_W, default 12, LED width; SHALL be <= 12.
REQ-003 Parameter TIMEOUT, default 255, maximum memory wait cycles before abort; SHALL be >= 1.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 Clk  in  1  rising-edge clock.
REQ-006 Reset_al  in  1  asynchronous active-low reset.
REQ-007 LD  in  8  load enables {LED,REG,CC,BEN,MDR,MAR,IR,PC}, bits 7..0.
REQ-008 GATE  in  4  bus drivers {MDR,MARMUX,PC,ALU}, bits 3..0.
REQ-009 MUXSEL  in  10  [1:0] PCMUX, [3:2] ADDR2MUX, [5:4] ALUK, [6] ADDR1MUX, [7] SR2MUX, [8] SR1MUX, [9] DRMUX.
REQ-010 MEM_RD  in  1  start a memory read into MDR.
REQ-011 MDR_In  in  W  memory read data.
REQ-012 MEM_RDY  in  1  memory data valid.
REQ-013 MEM_REQ  out  1  read request, high while waiting.
REQ-014 MDR_VALID  out  1  one-cycle pulse when a memory read completes.
REQ-015 MEM_TO  out  1  sticky flag: a read timed out.
REQ-016 IR, PC, MAR, MDR  out  W each  architectural registers.
REQ-017 NZP  out  3  condition codes {N,Z,P}.
REQ-018 BEN  out  1  registered branch enable.
REQ-019 LED  out  LED_W  LED register.
REQ-020 BUS_ERR  out  1  sticky bus-contention flag.

Function
REQ-021 Sign extension SHALL be to W bits: SEXT11=IR[10:0], SEXT9=IR[8:0], SEXT6=IR[5:0], SEXT5=IR[4:0].
REQ-022 PCMUX SHALL select the next PC: 00 BUS, 01 adder, 10 PC+1 (mod 2^W, wraps to 0), 11 hold PC.
REQ-023 Adder SHALL compute ADDR1 + ADDR2 mod 2^W.
  - ADDR1: 0 = PC, 1 = SR1.
  - ADDR2: 00 SEXT11, 01 SEXT9, 10 SEXT6, 11 zero.
REQ-024 Register file SHALL hold 8xW registers.
  - DR = DRMUX ? 7 : IR[11:9].
  - SR1 = SR1MUX ? IR[8:6] : IR[11:9].
  - SR2 = IR[2:0].
  - Written from BUS on LD[REG].
  - Reads are combinational, so old data is read in the write cycle.
REQ-025 ALU B operand = SR2MUX ? SEXT5 : SR2.
  - ALUK 00 ADD, 01 AND, 10 NOT SR1, 11 pass SR1.
REQ-026 BUS SHALL be the ALU output, PC, adder output or MDR per GATE, and zero when no gate is asserted.
REQ-027 On LD[CC], NZP SHALL load exactly one hot bit: N=BUS[W-1], Z=(BUS==0), P otherwise.
REQ-028 On LD[BEN], BEN SHALL load (IR[11]&N)|(IR[10]&Z)|(IR[9]&P) using the NZP value before this edge.
REQ-029 IR and MAR SHALL load BUS on LD[IR]/LD[MAR]; LED SHALL load IR[LED_W-1:0] on LD[LED].
REQ-030 Memory FSM states:
  - IDLE: MEM_RD -> WAIT, MEM_REQ=1, wait counter cleared.
  - WAIT: MEM_RDY -> MDR<=MDR_In, MDR_VALID pulse, IDLE.
  - WAIT: counter==TIMEOUT without MEM_RDY -> MDR<=0, MDR_VALID pulse, MEM_TO<=1, IDLE.
REQ-031 In IDLE, LD[MDR] SHALL load MDR from BUS; in WAIT, LD[MDR] SHALL be ignored.
REQ-032 MEM_RD in WAIT and MEM_RDY in IDLE SHALL be ignored.
REQ-033 If MEM_RDY arrives in the same cycle the counter reaches TIMEOUT, MEM_RDY SHALL win and MEM_TO SHALL stay 0.

Reset
REQ-034 Reset_al low SHALL immediately clear:
  - PC, IR, MAR, MDR, all registers, NZP, BEN, LED, MEM_TO, BUS_ERR to 0.
  - FSM to IDLE, with MEM_REQ=0 and MDR_VALID=0.
REQ-035 Reset during WAIT SHALL abort the read with no MDR_VALID pulse.

Configuration
REQ-036 With DATAPATH_BUS_CHECK_EN defined, more than one GATE bit high SHALL set BUS_ERR (sticky), and BUS SHALL use priority ALU>PC>MARMUX>MDR.
REQ-037 Without DATAPATH_BUS_CHECK_EN, BUS SHALL use the same priority and BUS_ERR SHALL be tied to 0.

Verification
REQ-038 PC=16'hFFFF, PCMUX=10, LD[PC] -> PC=16'h0000.
REQ-039 IR=16'h1261 (ADD R1,R1,#1), R1=16'hFFFF, GATE[ALU], LD[REG], LD[CC] -> R1=0, NZP=3'b010.
REQ-040 NZP=3'b100, IR=16'h0800, LD[BEN] -> BEN=1; with IR=16'h0200 -> BEN=0.
REQ-041 MEM_RD, MEM_RDY after 3 cycles with MDR_In=16'hBEEF -> MEM_REQ high 3 cycles, MDR=16'hBEEF, one MDR_VALID pulse.
REQ-042 MEM_RD, MEM_RDY never asserted, TIMEOUT=4 -> MDR=0 after 4 wait cycles, MEM_TO=1.
  - Reset_al low mid-WAIT -> IDLE, no MDR_VALID pulse.
REQ-043 Macro defined, GATE=4'b0011 -> BUS=ALU output, BUS_ERR=1 until reset.
